// File: rtl/pcileech_ft601_emu_pkg.sv
// Shared types and error-bit positions for the FT601 device-side bus emulator.
package pcileech_ft601_emu_pkg;

  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] data;
  } ft601_word_t;

  localparam int ERR_RD_EMPTY     = 0;
  localparam int ERR_WR_FULL      = 1;
  localparam int ERR_BUS_CONFLICT = 2;

endpackage

// File: rtl/pcileech_ft601_emu_fifo.sv
// Synchronous first-word-fall-through FIFO of ft601_word_t with a registered head word.
// A push and a pop in the same cycle are accepted even when full.
module pcileech_ft601_emu_fifo
  import pcileech_ft601_emu_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_push,
  input  ft601_word_t         i_din,
  input  logic                i_pop,
  output ft601_word_t         o_head,
  output logic [DEPTH_LOG2:0] o_count_next
);

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;

  localparam int   DEPTH = 1 << DEPTH_LOG2;
  localparam cnt_t FULL  = {1'b1, {DEPTH_LOG2{1'b0}}};

  ft601_word_t r_mem [DEPTH];
  ptr_t        r_wr_ptr;
  ptr_t        r_rd_ptr;
  cnt_t        r_count;
  ft601_word_t r_head;

  logic w_pop;
  logic w_push;
  ptr_t w_rd_ptr_next;
  cnt_t w_remain;

  assign w_pop         = i_pop && (r_count != '0);
  assign w_push        = i_push && ((r_count != FULL) || w_pop);
  assign w_rd_ptr_next = r_rd_ptr + ptr_t'(w_pop);
  assign w_remain      = r_count - cnt_t'(w_pop);
  assign o_count_next  = w_remain + cnt_t'(w_push);
  assign o_head        = r_head;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Head register tracks the word at the next read pointer; a push into an
  // otherwise-empty buffer bypasses the array so it is visible one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      r_count  <= o_count_next;
      r_rd_ptr <= w_rd_ptr_next;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ptr_t'(1);
      end
      if (w_push && (w_remain == '0)) begin
        r_head <= i_din;
      end else if (w_remain != '0) begin
        r_head <= r_mem[w_rd_ptr_next];
      end
    end
  end

endmodule

// File: rtl/pcileech_ft601_dev_emu.sv
// Device (chip) end of the FT601 32-bit synchronous 245-FIFO bus, with an RX buffer fed
// from the inj_* port and a TX buffer drained through the cap_* port.
module pcileech_ft601_dev_emu
  import pcileech_ft601_emu_pkg::*;
#(
  parameter int DEPTH_LOG2   = 10,
  parameter int TXE_THROTTLE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inj_data,
  input  logic [3:0]  inj_be,
  input  logic        inj_valid,
  output logic        inj_ready,
  output logic [31:0] cap_data,
  output logic [3:0]  cap_be,
  output logic        cap_valid,
  input  logic        cap_ready,
  input  logic [31:0] ft601_data_i,
  output logic [31:0] ft601_data_o,
  output logic        ft601_data_oe,
  input  logic [3:0]  ft601_be_i,
  output logic [3:0]  ft601_be_o,
  output logic        ft601_rxf_n,
  output logic        ft601_txe_n,
  input  logic        ft601_oe_n,
  input  logic        ft601_rd_n,
  input  logic        ft601_wr_n,
  output logic [2:0]  err_flags
);

  localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic r_rxf_n;
  logic r_txe_n;
  logic r_data_oe;
  logic r_inj_ready;
  logic r_cap_valid;
  logic [2:0] r_err;

  logic                w_rx_push;
  logic                w_rx_pop;
  logic                w_tx_push;
  logic                w_tx_pop;
  logic                w_thr_hit;
  ft601_word_t         w_rx_head;
  ft601_word_t         w_tx_head;
  ft601_word_t         w_inj_word;
  ft601_word_t         w_bus_word;
  logic [DEPTH_LOG2:0] w_rx_count_next;
  logic [DEPTH_LOG2:0] w_tx_count_next;

  assign w_inj_word = '{be: inj_be, data: inj_data};
  assign w_bus_word = '{be: ft601_be_i, data: ft601_data_i};

  // Strobes are qualified by the flags the FPGA saw on this edge, not by the buffer counts.
  assign w_rx_push = inj_valid && r_inj_ready;
  assign w_rx_pop  = !ft601_oe_n && !ft601_rd_n && !r_rxf_n;
  assign w_tx_push = !ft601_wr_n && !r_txe_n;
  assign w_tx_pop  = r_cap_valid && cap_ready;

  pcileech_ft601_emu_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_rx_push),
    .i_din        (w_inj_word),
    .i_pop        (w_rx_pop),
    .o_head       (w_rx_head),
    .o_count_next (w_rx_count_next)
  );

  pcileech_ft601_emu_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_tx_push),
    .i_din        (w_bus_word),
    .i_pop        (w_tx_pop),
    .o_head       (w_tx_head),
    .o_count_next (w_tx_count_next)
  );

  generate
    if (TXE_THROTTLE > 0) begin : g_throttle
      localparam int TW = (TXE_THROTTLE > 1) ? $clog2(TXE_THROTTLE) : 1;
      localparam logic [TW-1:0] LAST = TW'(TXE_THROTTLE - 1);
      logic [TW-1:0] r_thr_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_thr_cnt <= '0;
        end else if (r_thr_cnt == LAST) begin
          r_thr_cnt <= '0;
        end else begin
          r_thr_cnt <= r_thr_cnt + TW'(1);
        end
      end

      assign w_thr_hit = (r_thr_cnt == LAST);
    end else begin : g_no_throttle
      assign w_thr_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxf_n     <= 1'b1;
      r_txe_n     <= 1'b1;
      r_data_oe   <= 1'b0;
      r_inj_ready <= 1'b0;
      r_cap_valid <= 1'b0;
      r_err       <= '0;
    end else begin
      r_data_oe   <= !ft601_oe_n;
      r_rxf_n     <= (w_rx_count_next == '0);
      r_txe_n     <= (w_tx_count_next == FULL) || w_thr_hit;
      r_inj_ready <= (w_rx_count_next != FULL);
      r_cap_valid <= (w_tx_count_next != '0);
      if (!ft601_rd_n && !ft601_oe_n && r_rxf_n) begin
        r_err[ERR_RD_EMPTY] <= 1'b1;
      end
      if (!ft601_wr_n && r_txe_n) begin
        r_err[ERR_WR_FULL] <= 1'b1;
      end
      if (!ft601_oe_n && !ft601_wr_n) begin
        r_err[ERR_BUS_CONFLICT] <= 1'b1;
      end
    end
  end

  assign ft601_data_o  = w_rx_head.data;
  assign ft601_be_o    = w_rx_head.be;
  assign ft601_data_oe = r_data_oe;
  assign ft601_rxf_n   = r_rxf_n;
  assign ft601_txe_n   = r_txe_n;
  assign inj_ready     = r_inj_ready;
  assign cap_data      = w_tx_head.data;
  assign cap_be        = w_tx_head.be;
  assign cap_valid     = r_cap_valid;
  assign err_flags     = r_err;

endmodule

// File: tb/tb_pcileech_ft601_dev_emu.sv
// Self-checking bench: instance a (4-deep, no throttle) and instance b (16-deep, throttle 4).
module tb_pcileech_ft601_dev_emu;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [31:0] a_inj_data, a_cap_data, a_di, a_do;
  logic [3:0]  a_inj_be, a_cap_be, a_bei, a_beo;
  logic        a_inj_valid, a_inj_ready, a_cap_valid, a_cap_ready, a_oe;
  logic        a_rxf_n, a_txe_n, a_oe_n, a_rd_n, a_wr_n;
  logic [2:0]  a_err;

  logic [31:0] b_inj_data, b_cap_data, b_di, b_do;
  logic [3:0]  b_inj_be, b_cap_be, b_bei, b_beo;
  logic        b_inj_valid, b_inj_ready, b_cap_valid, b_cap_ready, b_oe;
  logic        b_rxf_n, b_txe_n, b_oe_n, b_rd_n, b_wr_n;
  logic [2:0]  b_err;

  pcileech_ft601_dev_emu #(.DEPTH_LOG2(2), .TXE_THROTTLE(0)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .inj_data(a_inj_data), .inj_be(a_inj_be), .inj_valid(a_inj_valid), .inj_ready(a_inj_ready),
    .cap_data(a_cap_data), .cap_be(a_cap_be), .cap_valid(a_cap_valid), .cap_ready(a_cap_ready),
    .ft601_data_i(a_di), .ft601_data_o(a_do), .ft601_data_oe(a_oe),
    .ft601_be_i(a_bei), .ft601_be_o(a_beo),
    .ft601_rxf_n(a_rxf_n), .ft601_txe_n(a_txe_n),
    .ft601_oe_n(a_oe_n), .ft601_rd_n(a_rd_n), .ft601_wr_n(a_wr_n),
    .err_flags(a_err)
  );

  pcileech_ft601_dev_emu #(.DEPTH_LOG2(4), .TXE_THROTTLE(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .inj_data(b_inj_data), .inj_be(b_inj_be), .inj_valid(b_inj_valid), .inj_ready(b_inj_ready),
    .cap_data(b_cap_data), .cap_be(b_cap_be), .cap_valid(b_cap_valid), .cap_ready(b_cap_ready),
    .ft601_data_i(b_di), .ft601_data_o(b_do), .ft601_data_oe(b_oe),
    .ft601_be_i(b_bei), .ft601_be_o(b_beo),
    .ft601_rxf_n(b_rxf_n), .ft601_txe_n(b_txe_n),
    .ft601_oe_n(b_oe_n), .ft601_rd_n(b_rd_n), .ft601_wr_n(b_wr_n),
    .err_flags(b_err)
  );

  typedef struct {
    logic [31:0] din;
    logic [3:0]  bein;
    logic [31:0] dexp;
    logic [3:0]  beexp;
  } vec_t;

  vec_t        vecs [8];
  logic [35:0] a_rxq [$];
  logic [35:0] a_txq [$];
  logic [35:0] b_txq [$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_inj_data = '0; a_inj_be = '0; a_inj_valid = 1'b0; a_cap_ready = 1'b0;
    a_di = '0; a_bei = '0; a_oe_n = 1'b1; a_rd_n = 1'b1; a_wr_n = 1'b1;
    b_inj_data = '0; b_inj_be = '0; b_inj_valid = 1'b0; b_cap_ready = 1'b0;
    b_di = '0; b_bei = '0; b_oe_n = 1'b1; b_rd_n = 1'b1; b_wr_n = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    a_rxq.delete(); a_txq.delete(); b_txq.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Capture-side scoreboards: one popped expectation per accepted cap word.
  always @(negedge clk) begin
    if (rst_n && a_cap_valid && a_cap_ready) begin
      if (a_txq.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_cap_extra actual=%h required=none", {a_cap_be, a_cap_data});
      end else begin
        chk("a_cap_word", {a_cap_be, a_cap_data}, a_txq.pop_front());
      end
    end
    if (rst_n && b_cap_valid && b_cap_ready) begin
      if (b_txq.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_cap_extra actual=%h required=none", {b_cap_be, b_cap_data});
      end else begin
        chk("b_cap_word", {b_cap_be, b_cap_data}, b_txq.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hi;
    int last_hi;
    rst_n = 1'b0;
    idle();
    repeat (2) tick();
    chk("rst_rxf_n", 36'(a_rxf_n), 36'd1);
    chk("rst_txe_n", 36'(a_txe_n), 36'd1);
    chk("rst_data_oe", 36'(a_oe), 36'd0);
    chk("rst_data_be_o", {a_beo, a_do}, 36'd0);
    chk("rst_inj_ready", 36'(a_inj_ready), 36'd0);
    chk("rst_cap_valid", 36'(a_cap_valid), 36'd0);
    chk("rst_err", 36'(a_err), 36'd0);
    rst_n = 1'b1;
    #1;
    chk("inj_ready_first_cycle", 36'(a_inj_ready), 36'd0);
    tick();
    chk("inj_ready_after", 36'(a_inj_ready), 36'd1);
    chk("txe_n_after_rst", 36'(a_txe_n), 36'd0);

    // 1: injected words read back over the bus in order
    for (int i = 0; i < 4; i++) begin
      vecs[i] = '{din: 32'h11111111 * (i + 1), bein: 4'hF, dexp: 32'h11111111 * (i + 1), beexp: 4'hF};
    end
    for (int i = 0; i < 4; i++) begin
      a_inj_data = vecs[i].din; a_inj_be = vecs[i].bein; a_inj_valid = 1'b1;
      a_rxq.push_back({vecs[i].beexp, vecs[i].dexp});
      tick();
    end
    a_inj_valid = 1'b0;
    chk("rx_full_inj_ready", 36'(a_inj_ready), 36'd0);
    a_oe_n = 1'b0;
    tick();
    chk("rd_data_oe", 36'(a_oe), 36'd1);
    for (int i = 0; i < 4; i++) begin
      a_rd_n = 1'b0;
      chk("rd_rxf_n_low", 36'(a_rxf_n), 36'd0);
      chk("rd_word", {a_beo, a_do}, a_rxq.pop_front());
      tick();
    end
    a_rd_n = 1'b1; a_oe_n = 1'b1;
    chk("rd_rxf_n_after_last", 36'(a_rxf_n), 36'd1);
    chk("rd_err", 36'(a_err), 36'd0);

    // 4: reads with RX empty
    do_reset();
    a_oe_n = 1'b0; a_rd_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("empty_rd_rxf_n", 36'(a_rxf_n), 36'd1);
      chk("empty_rd_data", {a_beo, a_do}, 36'd0);
    end
    a_oe_n = 1'b1; a_rd_n = 1'b1;
    chk("empty_rd_err", 36'(a_err), 36'd1);

    // 2: FPGA write stream through to capture port
    do_reset();
    a_cap_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{din: 32'hA0000000 + i, bein: (i == 5) ? 4'h3 : 4'hF,
                  dexp: 32'hA0000000 + i, beexp: (i == 5) ? 4'h3 : 4'hF};
    end
    for (int i = 0; i < 8; i++) begin
      a_wr_n = 1'b1;
      n = 0;
      while (a_txe_n && n < 20) begin
        tick();
        n++;
      end
      if (n >= 20) begin
        checks++; errors++;
        $display("FAIL wr_wait_txe actual=timeout required=txe_n_low");
      end
      a_di = vecs[i].din; a_bei = vecs[i].bein; a_wr_n = 1'b0;
      a_txq.push_back({vecs[i].beexp, vecs[i].dexp});
      tick();
    end
    a_wr_n = 1'b1;
    repeat (6) tick();
    chk("wr_stream_drained", 36'(a_txq.size()), 36'd0);
    chk("wr_stream_err", 36'(a_err), 36'd0);

    // 3: fill 4-deep TX, overflow, then drain
    do_reset();
    a_cap_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_di = 32'hB0000000 + i; a_bei = 4'hF; a_wr_n = 1'b0;
      if (i < 4) a_txq.push_back({4'hF, 32'hB0000000 + i});
      tick();
      if (i < 3) chk("fill_txe_n_low", 36'(a_txe_n), 36'd0);
      if (i == 3) chk("fill_txe_n_full", 36'(a_txe_n), 36'd1);
    end
    a_wr_n = 1'b1;
    chk("overflow_err", 36'(a_err), 36'd2);
    chk("overflow_cap_valid", 36'(a_cap_valid), 36'd1);
    a_cap_ready = 1'b1;
    tick();
    chk("drain_txe_n_low", 36'(a_txe_n), 36'd0);
    repeat (6) tick();
    chk("overflow_drained", 36'(a_txq.size()), 36'd0);
    a_cap_ready = 1'b0;

    // 5: throttled TX on instance b
    b_cap_ready = 1'b1;
    hi = 0; last_hi = -1; n = 0;
    for (int c = 0; c < 40; c++) begin
      if (!b_txe_n) begin
        b_di = 32'hC0000000 + n; b_bei = 4'hF; b_wr_n = 1'b0;
        b_txq.push_back({4'hF, 32'hC0000000 + n});
        n++;
      end else begin
        b_wr_n = 1'b1;
        hi++;
        if (last_hi >= 0) chk("thr_period", 36'(c - last_hi), 36'd4);
        last_hi = c;
      end
      tick();
    end
    b_wr_n = 1'b1;
    chk("thr_high_count", 36'(hi), 36'd10);
    repeat (6) tick();
    chk("thr_no_loss", 36'(b_txq.size()), 36'd0);
    chk("thr_err", 36'(b_err), 36'd0);
    b_cap_ready = 1'b0;

    // 6: asynchronous reset in the middle of a read burst
    do_reset();
    for (int i = 0; i < 3; i++) begin
      a_inj_data = 32'hD0000000 + i; a_inj_be = 4'hF; a_inj_valid = 1'b1;
      tick();
    end
    a_inj_valid = 1'b0;
    a_di = 32'hE0000000; a_bei = 4'hF; a_wr_n = 1'b0;
    tick();
    a_wr_n = 1'b1; a_oe_n = 1'b0;
    tick();
    a_rd_n = 1'b0;
    tick();
    chk("pre_rst_rxf_n", 36'(a_rxf_n), 36'd0);
    chk("pre_rst_cap_valid", 36'(a_cap_valid), 36'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rxf_n", 36'(a_rxf_n), 36'd1);
    chk("async_rst_data_oe", 36'(a_oe), 36'd0);
    chk("async_rst_cap_valid", 36'(a_cap_valid), 36'd0);
    chk("async_rst_data_o", {a_beo, a_do}, 36'd0);
    idle();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_err", 36'(a_err), 36'd0);
    chk("post_rst_rxf_n", 36'(a_rxf_n), 36'd1);
    chk("post_rst_cap_valid", 36'(a_cap_valid), 36'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
